// File: rtl/op2_stage.sv
// op2_stage: ARM A32 operand-2 shifter stage with Rs fetch and valid/ready output handshake
module op2_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] instr,
    input  logic [31:0] rm_data,
    input  logic        c_in,
    output logic        rs_req,
    output logic [3:0]  rs_addr,
    input  logic        rs_valid,
    input  logic [31:0] rs_data,
    input  logic        flush,
    output logic [31:0] op2,
    output logic        c_out,
    output logic        valid,
    input  logic        ready,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, RS_WAIT, CALC, DONE} state_t;
    state_t      state;
    logic        i_bit, cin_q, reg_form, rrx, sh_c, c_res;
    logic [11:0] fld;
    logic [31:0] rm_q, imm, ror_r, sh_res, res;
    logic [7:0]  amt_q, eff;
    logic [1:0]  sh_type;
    logic [32:0] lsl_t, lsr_t, asr_t;

    function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] n);
        return (x >> n) | (x << (6'd32 - {1'b0, n}));
    endfunction

    assign sh_type  = fld[6:5];
    assign imm      = ror32({24'd0, fld[7:0]}, {fld[11:8], 1'b0});
    assign reg_form = !i_bit && fld[4];
    assign rrx      = !i_bit && !fld[4] && sh_type == 2'd3 && fld[11:7] == 5'd0;
    // imm5 LSR/ASR #0 encode a shift of 32; amounts stay 8 bits wide for the >=32 cases
    assign eff      = reg_form ? amt_q : (fld[11:7] == 5'd0 && sh_type != 2'd0) ? 8'd32 : {3'd0, fld[11:7]};
    assign lsl_t    = {1'b0, rm_q} << eff;
    assign lsr_t    = {rm_q, 1'b0} >> eff;
    assign asr_t    = $signed({rm_q, 1'b0}) >>> eff;
    assign ror_r    = ror32(rm_q, eff[4:0]);
    assign sh_res   = eff == 8'd0 ? rm_q : sh_type == 2'd0 ? lsl_t[31:0] : sh_type == 2'd1 ? lsr_t[32:1] :
                      sh_type == 2'd2 ? asr_t[32:1] : ror_r;
    assign sh_c     = eff == 8'd0 ? cin_q : sh_type == 2'd0 ? lsl_t[32] : sh_type == 2'd1 ? lsr_t[0] :
                      sh_type == 2'd2 ? asr_t[0] : ror_r[31];
    assign res      = i_bit ? imm : rrx ? {cin_q, rm_q[31:1]} : sh_res;
    assign c_res    = i_bit ? (fld[11:8] == 4'd0 ? cin_q : imm[31]) : rrx ? rm_q[0] : sh_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            i_bit   <= 1'b0;
            fld     <= '0;
            rm_q    <= '0;
            cin_q   <= 1'b0;
            amt_q   <= '0;
            op2     <= '0;
            c_out   <= 1'b0;
            valid   <= 1'b0;
            rs_req  <= 1'b0;
            rs_addr <= '0;
            busy    <= 1'b0;
        end else if (flush) begin
            state  <= IDLE;
            valid  <= 1'b0;
            rs_req <= 1'b0;
            busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    i_bit <= instr[25];
                    fld   <= instr[11:0];
                    rm_q  <= rm_data;
                    cin_q <= c_in;
                    busy  <= 1'b1;
                    if (!instr[25] && instr[4]) begin
                        state   <= RS_WAIT;
                        rs_req  <= 1'b1;
                        rs_addr <= instr[11:8];
                    end else begin
                        state <= CALC;
                    end
                end
                RS_WAIT: if (rs_valid) begin
                    amt_q  <= rs_data[7:0];
                    rs_req <= 1'b0;
                    state  <= CALC;
                end
                CALC: begin
                    op2   <= res;
                    c_out <= c_res;
                    state <= DONE;
                end
                DONE: begin
                    // result settles one cycle before valid is raised
                    if (valid && ready) begin
                        valid <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
